// File: rtl/input_skew_pkg.sv
// Shared types for the input skew buffer: FSM state encoding.
package input_skew_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Valid+data shift register of DEPTH stages with shift-enable and synchronous clear.
// Invalid entries always enter with zero data so the array never sees stale payload.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_shift) begin
            valid_d[0] = i_valid;
            data_d[0]  = i_valid ? i_data : '0;
            for (int s = 1; s < DEPTH; s++) begin
                valid_d[s] = valid_q[s-1];
                data_d[s]  = data_q[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q[DEPTH-1];
    assign o_data  = data_q[DEPTH-1];

endmodule

// File: rtl/input_skew_buffer.sv
// Pops row-parallel activations from the router and skews them diagonally (row r
// delayed r cycles beyond row 0) into the PE array; drains its delay lines at tile end.
module input_skew_buffer
    import input_skew_pkg::*;
#(
    parameter int ROW_COUNT  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_en,
    input  logic                                 i_reg_clear,
    input  logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] i_data,
    input  logic [ROW_COUNT-1:0]                 i_data_valid,
    input  logic                                 i_data_out_ready,
    input  logic                                 i_rerouting,
    output logic                                 o_data_out_en,
    input  logic                                 i_array_stall,
    output logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] o_data,
    output logic [ROW_COUNT-1:0]                 o_data_valid,
    output logic                                 o_busy,
    output logic                                 o_drain_done,
    output skew_state_t                          o_dbg_state
);

    // Handshake: the router presents data with i_data_out_ready; a word is taken in
    // any cycle where o_data_out_en is high, and it is captured at that clock edge.
    localparam int                CNT_W    = $clog2(ROW_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ROW_COUNT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    skew_state_t       state_q, state_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              drain_done_q, drain_done_d;
    logic              advance;
    logic              stream_end;
    logic              line_clear;
    logic [ROW_COUNT-1:0] stage0_valid;

    assign advance    = i_en & ~i_array_stall;
    assign stream_end = ~i_data_out_ready | i_rerouting;
    assign line_clear = i_rst | i_reg_clear;

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_en & i_data_out_ready & ~i_rerouting) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A stalled cycle never exits; the end condition is re-tested on the next advance.
                if (advance & stream_end) begin
                    state_d     = DRAIN;
                    drain_cnt_d = CNT_LOAD;
                end
            end
            DRAIN: begin
                if (advance) begin
                    if (drain_cnt_q <= CNT_ONE) begin
                        drain_cnt_d  = '0;
                        state_d      = IDLE;
                        drain_done_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_reg_clear) begin
            state_q      <= IDLE;
            drain_cnt_q  <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            drain_done_q <= drain_done_d;
        end
    end

    // While draining, bubbles are injected so the tail of the stream flushes out.
    assign stage0_valid = i_data_valid & {ROW_COUNT{state_q != DRAIN}};

    for (genvar r = 0; r < ROW_COUNT; r++) begin : g_row
        skew_delay_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line (
            .i_clk   (i_clk),
            .i_clear (line_clear),
            .i_shift (advance),
            .i_valid (stage0_valid[r]),
            .i_data  (i_data[r]),
            .o_valid (o_data_valid[r]),
            .o_data  (o_data[r])
        );
    end

    assign o_data_out_en = (state_q == STREAM) & advance & i_data_out_ready & ~i_rerouting;
    assign o_busy        = (state_q != IDLE);
    assign o_drain_done  = drain_done_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_input_skew_buffer.sv
// Bench for input_skew_buffer: directed scenarios plus random traffic, checked against
// a queue-based model of the skew/drain behaviour by a negedge monitor.
module tb_input_skew_buffer;
    import input_skew_pkg::*;

    localparam int ROWS = 4;
    localparam int DW   = 8;
    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_DRAIN  = 2;

    typedef struct {
        logic [DW-1:0] d;
        int unsigned   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, clr, ready, rr, stall;
    logic [ROWS-1:0][DW-1:0] data;
    logic [ROWS-1:0]         valid;
    logic                    pop_en, busy, done;
    logic [ROWS-1:0][DW-1:0] o_data;
    logic [ROWS-1:0]         o_valid;
    skew_state_t             dbg_state;

    exp_t        exp_q[ROWS][$];
    int          mode = M_IDLE;
    int unsigned adv_n = 0;
    int unsigned drain_end = 0;
    logic        done_exp = 1'b0;
    logic        mon_on = 1'b0;
    int          total = 0;
    int          bad = 0;

    input_skew_buffer #(.ROW_COUNT(ROWS), .DATA_WIDTH(DW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_en             (en),
        .i_reg_clear      (clr),
        .i_data           (data),
        .i_data_valid     (valid),
        .i_data_out_ready (ready),
        .i_rerouting      (rr),
        .o_data_out_en    (pop_en),
        .i_array_stall    (stall),
        .o_data           (o_data),
        .o_data_valid     (o_valid),
        .o_busy           (busy),
        .o_drain_done     (done),
        .o_dbg_state      (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: every advance edge captures the row inputs (bubbles while
    // draining); a sample taken at advance number k is visible on row r while the
    // advance count equals k+r. Drain finishes ROWS advances after the exit edge.
    task automatic model_edge();
        logic adv;
        if (rst || clr) begin
            for (int r = 0; r < ROWS; r++) exp_q[r].delete();
            mode     = M_IDLE;
            done_exp = 1'b0;
            return;
        end
        adv      = en && !stall;
        done_exp = 1'b0;
        if (adv) begin
            adv_n++;
            if (mode != M_DRAIN) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (valid[r]) exp_q[r].push_back('{d: data[r], due: adv_n + r});
                end
            end
        end
        case (mode)
            M_IDLE:   if (en && ready && !rr) mode = M_STREAM;
            M_STREAM: if (adv && (!ready || rr)) begin
                mode      = M_DRAIN;
                drain_end = adv_n + ROWS;
            end
            default:  if (adv && adv_n == drain_end) begin
                mode     = M_IDLE;
                done_exp = 1'b1;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Monitor / scoreboard
    task automatic monitor_cycle();
        logic        exp_pop;
        skew_state_t exp_st;
        exp_pop = (mode == M_STREAM) && en && !stall && ready && !rr;
        exp_st  = (mode == M_IDLE) ? IDLE : (mode == M_STREAM) ? STREAM : DRAIN;
        check("pop_en", 32'(pop_en), 32'(exp_pop));
        check("busy", 32'(busy), 32'(mode != M_IDLE));
        check("drain_done", 32'(done), 32'(done_exp));
        check("state", 32'(dbg_state), 32'(exp_st));
        for (int r = 0; r < ROWS; r++) begin
            while (exp_q[r].size() > 0 && exp_q[r][0].due < adv_n) void'(exp_q[r].pop_front());
            if (exp_q[r].size() > 0 && exp_q[r][0].due == adv_n)
                check($sformatf("row%0d", r), 32'({o_valid[r], o_data[r]}), 32'({1'b1, exp_q[r][0].d}));
            else
                check($sformatf("row%0d", r), 32'({o_valid[r], o_data[r]}), 32'(0));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) monitor_cycle();
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic e, input logic s, input logic rdy, input logic rrt);
        en = e; stall = s; ready = rdy; rr = rrt;
    endtask

    task automatic set_beat(input logic [ROWS-1:0] v, input int base);
        valid = v;
        for (int r = 0; r < ROWS; r++) data[r] = DW'(8'h10 * (r + 1) + base);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("wait_idle_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        valid = '0; data = '0;
        tick();
        rst = 1'b0;
        mon_on = 1'b1;
        check("reset_outputs", 32'({pop_en, busy, done, o_valid, o_data}), 32'(0));

        // enable low keeps FSM idle and no pops
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
        valid = '1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("en_low_pop", 32'(pop_en), 32'(0));
            check("en_low_busy", 32'(busy), 32'(0));
            tick();
        end

        // basic skew stream of three beats, then drain
        valid = '0;
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_beat('1, b);
            tick();
            if (b == 0) check("basic_row0_first", 32'({o_valid[0], o_data[0]}), 32'({1'b1, 8'h10}));
        end
        set_beat('0, 0);
        ready = 1'b0;
        #2;
        check("pop_off_at_exit", 32'(pop_en), 32'(0));
        tick();
        check("basic_row3_first", 32'({o_valid[3], o_data[3]}), 32'({1'b1, 8'h40}));
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("drain_latency", 32'(n), 32'(ROWS + 1));
        check("idle_after_drain", 32'(busy), 32'(0));

        // back-to-back stream with a 2-cycle stall mid-stream
        ready = 1'b1;
        tick();
        set_beat('1, 3);
        tick();
        set_beat('1, 4);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            check("stall_pop", 32'(pop_en), 32'(0));
            tick();
        end
        stall = 1'b0;
        tick();
        set_beat('1, 5);
        tick();
        set_beat('0, 0);
        ready = 1'b0;
        tick();
        wait_idle();

        // partial valid rows
        ready = 1'b1;
        tick();
        valid = 4'b0101;
        for (int r = 0; r < ROWS; r++) data[r] = 8'hFF;
        tick();
        check("partial_row0", 32'({o_valid[0], o_data[0]}), 32'({1'b1, 8'hFF}));
        valid = '0; ready = 1'b0;
        tick();
        check("partial_row1", 32'({o_valid[1], o_data[1]}), 32'(0));
        tick();
        check("partial_row2", 32'({o_valid[2], o_data[2]}), 32'({1'b1, 8'hFF}));
        wait_idle();

        // clear during drain with two drain steps left
        ready = 1'b1;
        tick();
        set_beat('1, 8);
        tick();
        set_beat('0, 0);
        ready = 1'b0;
        tick();
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clear_outputs", 32'({busy, done, o_valid, o_data}), 32'(0));
        n = 0;
        for (int i = 0; i < ROWS + 3; i++) begin
            tick();
            if (done) n++;
        end
        check("clear_no_done", 32'(n), 32'(0));

        // random traffic
        for (int i = 0; i < 500; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            ready = ($urandom_range(0, 7) != 0);
            rr    = ($urandom_range(0, 15) == 0);
            clr   = ($urandom_range(0, 79) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            valid = ROWS'($urandom);
            for (int r = 0; r < ROWS; r++) data[r] = DW'($urandom);
            tick();
        end
        rst = 1'b0; clr = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        valid = '0;
        tick();
        wait_idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
